rnd_arb: RTL and testbench
==========================

RND_ARB -- requirements
Module: rnd_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one generator.
REQ-002 SHALL have parameter WIDTH, default 8: random word width.
REQ-003 SHALL have parameter TAPS, default 8'hB8: Galois mask passed to the generator.
REQ-004 SHALL have parameter WARMUP, default 8: generator steps discarded after every seed load.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port seed_wr  input  1  one-cycle pulse: capture seed_in and reseed.
REQ-008 SHALL have port seed_in  input  WIDTH  new seed value.
REQ-009 SHALL have port req  input  N_REQ  level request per requester, held until its gnt.
REQ-010 SHALL have port gnt  output  N_REQ  one-hot, one-cycle pulse: rnd_out valid for that requester.
REQ-011 SHALL have port rnd_out  output  WIDTH  delivered value; meaningful only while gnt is non-zero.
REQ-012 SHALL have port ready  output  1  high only in IDLE with no pending reseed.

Function
REQ-013 SHALL implement FSM states LOAD, WARM, IDLE, STEP, DELIVER.
REQ-014 LOAD SHALL drive the generator load_seed for 1 cycle, then go to WARM.
REQ-015 WARM SHALL drive the generator en for exactly WARMUP cycles, counted by a down-counter, then go to IDLE; no gnt SHALL occur in LOAD or WARM.
REQ-016 IDLE with a pending reseed SHALL go to LOAD; reseed takes priority over any req.
REQ-017 IDLE with no pending reseed and req != 0 SHALL latch one winner by round-robin, searching from index last+1 upward with wrap, and go to STEP.
REQ-018 STEP SHALL drive en for 1 cycle, then go to DELIVER.
REQ-019 DELIVER SHALL pulse gnt[winner], present rnd_out = the post-step generator state, set last = winner, and return to IDLE.
REQ-020 Timing: req sampled in IDLE at cycle T SHALL produce gnt at T+2; maximum throughput is 1 grant per 3 cycles.
REQ-021 Every delivered value SHALL come from a fresh step; no two grants SHALL ever receive the same generator state.
REQ-022 The generator en and load_seed SHALL be low in IDLE and DELIVER.
REQ-023 seed_wr in any state SHALL set seed_q <= seed_in and a pending flag; the flag is cleared on entry to LOAD; a second seed_wr before LOAD overwrites seed_q (last one wins).
REQ-024 A seed_wr in IDLE SHALL be serviced on the next IDLE evaluation, ahead of any req in that cycle.
REQ-025 A winner SHALL receive its gnt even if its req drops during STEP; dropping req before gnt is a requester protocol violation.
REQ-026 seed_in == 0 SHALL behave as seed 1, through the generator's zero-seed forcing.
REQ-027 gnt SHALL be 0 and rnd_out SHALL be 0 in all states except DELIVER.

Reset
REQ-028 rst SHALL asynchronously force state=LOAD, seed_q=1, pending=0, last=N_REQ-1, counter=WARMUP, gnt=0, rnd_out=0, ready=0.
REQ-029 The generator's synchronous active-low reset SHALL be driven by !rst, so it reloads seed_q while rst is held; LOAD reloads it again after release.
REQ-030 rst asserted mid-grant, in STEP or DELIVER, SHALL abort the grant: no gnt pulse, and full LOAD+WARM on release.

Structure
REQ-031 The state encoding and default WARMUP/TAPS values SHALL live in a shared package rnd_pkg.
REQ-032 SHALL instantiate exactly one rnd_gen sub-module with WIDTH and TAPS passed through; all arbitration logic SHALL stay in rnd_arb.

Verification
REQ-033 Reset release, seed_q=8'h01, req=4'b0001 held -> ready rises after 1+8 cycles; first gnt=4'b0001 with rnd_out=8'h32, second with 8'h19.
REQ-034 req=4'b1111 held -> gnt order 0001,0010,0100,1000,0001, each 3 cycles apart; values B4,... with no repeats.
REQ-035 seed_wr with seed_in=8'h00 and req in the same IDLE cycle -> LOAD first, then the same sequence as seed 8'h01 (first value 8'h32).
REQ-036 seed_wr pulsed during DELIVER -> the grant completes, then LOAD+WARM follows before any further gnt.
REQ-037 rst asserted during STEP -> no gnt is produced; after release, behaviour matches REQ-033.
REQ-038 Generator run for 255 grants -> all 255 values are distinct and non-zero, and the 256th equals the 1st.

Source files
------------

// File: rtl/rnd_pkg.sv
// Shared definitions for the random-number arbiter: FSM encoding and generator defaults.
package rnd_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_WARM    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_STEP    = 3'd3,
    ST_DELIVER = 3'd4
  } state_e;

  localparam int         DEF_WARMUP = 8;
  localparam logic [7:0] DEF_TAPS   = 8'hB8;

  // True in the states that advance or load the generator.
  function automatic logic gen_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_WARM) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/rnd_gen.sv
// Galois LFSR generator: synchronous active-low reset and load both take the seed, zero forced to 1.
module rnd_gen
  import rnd_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load_seed,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_next_state
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_seed_nz;
  logic [WIDTH-1:0] w_step;

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  assign w_seed_nz    = (i_seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : i_seed;
  assign w_step       = {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? TAPS : '0);
  assign o_next_state = w_step;

  // Generator state register
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= w_seed_nz;
    end else if (i_load_seed) begin
      r_state <= w_seed_nz;
    end else if (i_en) begin
      r_state <= w_step;
    end else begin
      r_state <= r_state;
    end
  end

endmodule

// File: rtl/rnd_arb.sv
// Round-robin arbiter handing out one fresh LFSR word per grant, with reseed and warm-up.
module rnd_arb
  import rnd_pkg::*;
#(
  parameter int               N_REQ  = 4,
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEF_TAPS),
  parameter int               WARMUP = DEF_WARMUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_wr,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [WIDTH-1:0] rnd_out,
  output logic             ready
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(WARMUP + 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_seed_q;
  logic             r_pending;
  logic             w_pending_next;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_win;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [WIDTH-1:0] r_rnd_out;
  logic             r_ready;
  logic             w_reseed;
  logic             w_gen_load;
  logic             w_gen_en;
  logic             w_gen_rst_n;
  logic [WIDTH-1:0] w_gen_next;

  assign gnt         = r_gnt;
  assign rnd_out     = r_rnd_out;
  assign ready       = r_ready;
  assign w_gen_rst_n = ~rst;
  // A seed write arriving in the IDLE cycle itself already beats any request.
  assign w_reseed    = r_pending | seed_wr;

  rnd_gen #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_gen (
    .clk          (clk),
    .i_rst_n      (w_gen_rst_n),
    .i_load_seed  (w_gen_load),
    .i_en         (w_gen_en),
    .i_seed       (r_seed_q),
    .o_next_state (w_gen_next)
  );

  // Round-robin search starting just above the previous winner
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = IW'((int'(r_last) + i) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state and generator control
  always_comb begin
    w_next_state = r_state;
    w_gen_load   = 1'b0;
    w_gen_en     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_gen_load   = 1'b1;
        w_next_state = ST_WARM;
      end
      ST_WARM: begin
        w_gen_en = 1'b1;
        if (r_cnt <= CW'(1)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WARM;
        end
      end
      ST_IDLE: begin
        if (w_reseed) begin
          w_next_state = ST_LOAD;
        end else if (req != '0) begin
          w_next_state = ST_STEP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_STEP: begin
        w_gen_en     = 1'b1;
        w_next_state = ST_DELIVER;
      end
      ST_DELIVER: w_next_state = ST_IDLE;
      default:    w_next_state = ST_LOAD;
    endcase
  end

  // Entering LOAD consumes the latest seed, so the pending flag drops there
  always_comb begin
    w_pending_next = r_pending;
    if ((w_next_state == ST_LOAD) && (r_state != ST_LOAD)) begin
      w_pending_next = 1'b0;
    end else if (seed_wr) begin
      w_pending_next = 1'b1;
    end else begin
      w_pending_next = r_pending;
    end
  end

  // Arbiter state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_LOAD;
      r_seed_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_pending <= 1'b0;
      r_last    <= IW'(N_REQ - 1);
      r_win     <= IW'(N_REQ - 1);
      r_cnt     <= CW'(WARMUP);
      r_gnt     <= '0;
      r_rnd_out <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_pending_next;
      r_ready   <= (w_next_state == ST_IDLE) && !w_pending_next;
      if (seed_wr) begin
        r_seed_q <= seed_in;
      end
      if (r_state == ST_LOAD) begin
        r_cnt <= CW'(WARMUP);
      end else if (r_state == ST_WARM) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if ((r_state == ST_IDLE) && (w_next_state == ST_STEP)) begin
        r_win <= w_win;
      end
      if (r_state == ST_DELIVER) begin
        r_last <= r_win;
      end
      // The generator steps on this same edge, so its next state is the delivered word.
      if (r_state == ST_STEP) begin
        r_gnt     <= N_REQ'(1) << r_win;
        r_rnd_out <= w_gen_next;
      end else begin
        r_gnt     <= '0;
        r_rnd_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rnd_arb.sv
// Self-checking bench for rnd_arb: vector table plus reseed, reset-abort and full-period sequences.
module tb_rnd_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_wr;
  logic [7:0] seed_in;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] rnd_out;
  logic       ready;

  rnd_arb #(
    .N_REQ  (4),
    .WIDTH  (8),
    .TAPS   (8'hB8),
    .WARMUP (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seed_wr (seed_wr),
    .seed_in (seed_in),
    .req     (req),
    .gnt     (gnt),
    .rnd_out (rnd_out),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] rnd;
  } exp_t;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] rnd;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_gnt    = 0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (gnt == 4'b0000) begin
      check("rnd_out_quiet", 32'(rnd_out), 32'd0);
    end else begin
      n_gnt++;
    end
  endtask

  task automatic wait_ready(input string name, input int exp_n);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      n++;
      if (ready) ok = 1'b1;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic do_grant(input string name, output logic [7:0] got);
    bit   ok;
    exp_t e;
    ok  = 1'b0;
    got = 8'h00;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (gnt != 4'b0000) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no grant within 20 cycles", name);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end else if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected grant gnt=%b rnd=%0h", name, gnt, rnd_out);
    end else begin
      e = sb_q.pop_front();
      check({name, "_gnt"}, 32'(gnt), 32'(e.gnt));
      check({name, "_rnd"}, 32'(rnd_out), 32'(e.rnd));
      got = rnd_out;
    end
  endtask

  vec_t       vecs[7];
  logic [7:0] vals[256];
  logic [7:0] got;
  logic [7:0] m;
  bit         seen[256];
  int         t0;
  int         t_last;
  int         n0;
  int         dups;
  int         zeros;

  initial begin
    vecs[0] = '{4'b0001, 4'b0001, 8'h32};
    vecs[1] = '{4'b0001, 4'b0001, 8'h19};
    vecs[2] = '{4'b1111, 4'b0010, 8'hB4};
    vecs[3] = '{4'b1111, 4'b0100, 8'h5A};
    vecs[4] = '{4'b1111, 4'b1000, 8'h2D};
    vecs[5] = '{4'b1111, 4'b0001, 8'hAE};
    vecs[6] = '{4'b1111, 4'b0010, 8'h57};

    rst     = 1'b1;
    seed_wr = 1'b0;
    seed_in = 8'h00;
    req     = 4'b0001;
    repeat (3) tick();
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_rnd", 32'(rnd_out), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);

    // Reset release with requester 0 held, then a mixed round-robin run
    rst = 1'b0;
    t0  = cyc;
    wait_ready("ready_after_reset", 9);
    t_last = cyc;
    for (int i = 0; i < 7; i++) begin
      req = vecs[i].req;
      sb_q.push_back('{vecs[i].gnt, vecs[i].rnd});
      do_grant($sformatf("vec%0d", i), got);
      if (i == 0) begin
        check("first_gnt_latency", 32'(cyc - t0), 32'd11);
      end else begin
        check($sformatf("vec%0d_spacing", i), 32'(cyc - t_last), 32'd3);
      end
      t_last = cyc;
    end
    req = 4'b0000;
    tick();
    check("ready_idle", 32'(ready), 32'd1);

    // Zero seed written together with a request: reload wins, then seed-1 sequence
    seed_wr = 1'b1;
    seed_in = 8'h00;
    req     = 4'b0001;
    t0      = cyc;
    tick();
    seed_wr = 1'b0;
    check("ready_drops_on_reseed", 32'(ready), 32'd0);
    sb_q.push_back('{4'b0001, 8'h32});
    do_grant("reseed0_first", vals[0]);
    check("reseed0_latency", 32'(cyc - t0), 32'd12);
    m = 8'h32;
    for (int i = 1; i < 256; i++) begin
      m = lfsr_step(m);
      sb_q.push_back('{4'b0001, m});
      do_grant($sformatf("seq%0d", i), vals[i]);
    end
    req   = 4'b0000;
    dups  = 0;
    zeros = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (vals[i] == 8'h00) zeros++;
      if (seen[vals[i]]) dups++;
      seen[vals[i]] = 1'b1;
    end
    check("period_distinct", 32'(dups), 32'd0);
    check("period_nonzero", 32'(zeros), 32'd0);
    check("period_wrap", 32'(vals[255]), 32'(vals[0]));

    // Seed write during DELIVER: grant completes, then a full reload before the next one
    tick();
    req = 4'b0001;
    m   = lfsr_step(m);
    sb_q.push_back('{4'b0001, m});
    do_grant("deliver_reseed_a", got);
    seed_wr = 1'b1;
    seed_in = 8'h5A;
    t0      = cyc;
    tick();
    seed_wr = 1'b0;
    m = 8'h5A;
    for (int i = 0; i < 9; i++) m = lfsr_step(m);
    sb_q.push_back('{4'b0001, m});
    do_grant("deliver_reseed_b", got);
    check("deliver_reseed_gap", 32'(cyc - t0), 32'd13);
    req = 4'b0000;
    tick();

    // Reset asserted in STEP aborts the grant
    check("ready_before_abort", 32'(ready), 32'd1);
    req = 4'b0001;
    tick();
    rst = 1'b1;
    n0  = n_gnt;
    repeat (3) tick();
    check("abort_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    t0  = cyc;
    wait_ready("ready_after_abort", 9);
    sb_q.push_back('{4'b0001, 8'h32});
    sb_q.push_back('{4'b0001, 8'h19});
    do_grant("abort_first", got);
    check("abort_first_latency", 32'(cyc - t0), 32'd11);
    do_grant("abort_second", got);
    check("abort_no_stray_gnt", 32'(n_gnt - n0), 32'd2);
    req = 4'b0000;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
